lpc_cycle_decoder: RTL and testbench

Parametrised passive LPC bus decoder and the successor to the fixed single-byte `lpc` sniffer core. It samples LAD[3:0]/LFRAME# on every `lpc_clock` edge and decodes:
- IO read/write cycles
- memory read/write cycles
- firmware-memory read/write cycles with 1/2/4-byte bursts

It tracks SYNC wait states, abort and timeout. Each completed cycle is presented as one strobed record to the capture/FIFO logic downstream.

---
 rtl/lpc_pkg.sv | 63 ++++++
 rtl/lpc_nibble_acc.sv | 51 +++++
 rtl/lpc_cycle_decoder.sv | 235 +++++++++++++++++++++++
 tb/tb_lpc_cycle_decoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the passive LPC cycle decoder.
// Holds the FSM state type, the START/CT/SYNC/MSIZE nibble codes, the record field widths,
// and small helpers for MSIZE decoding and saturating nibble counting.
package lpc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCtdir,
    StIdsel,
    StAddr,
    StMsize,
    StDataW,
    StTar1,
    StSync,
    StDataR,
    StTar2,
    StDone
  } lpc_state_e;

  // START nibbles, sampled while LFRAME# is low
  localparam logic [3:0] StartLpc   = 4'b0000;
  localparam logic [3:0] StartFwRd  = 4'b1101;
  localparam logic [3:0] StartFwWr  = 4'b1110;
  localparam logic [3:0] StartAbort = 4'b1111;

  // Cycle type, bits [3:2] of the CTDIR nibble and of the output record
  localparam logic [1:0] CtIo  = 2'b00;
  localparam logic [1:0] CtMem = 2'b01;
  localparam logic [1:0] CtDma = 2'b10;
  localparam logic [1:0] CtFw  = 2'b11;

  localparam logic [3:0] SyncReady     = 4'b0000;
  localparam logic [3:0] SyncShortWait = 4'b0101;
  localparam logic [3:0] SyncLongWait  = 4'b0110;
  localparam logic [3:0] SyncError     = 4'b1010;

  localparam logic [3:0] Msize1 = 4'b0000;
  localparam logic [3:0] Msize2 = 4'b0001;
  localparam logic [3:0] Msize4 = 4'b0010;

  localparam int unsigned AddrW  = 32;
  localparam int unsigned CtDirW = 4;
  localparam int unsigned SizeW  = 3;

  // Accumulator modes
  localparam logic AccMsbFirst    = 1'b0;
  localparam logic AccLowNibFirst = 1'b1;

  // Byte count for an MSIZE nibble; 0 marks an illegal code.
  function automatic logic [SizeW-1:0] msize_bytes(input logic [3:0] msize);
    case (msize)
      Msize1:  return 3'd1;
      Msize2:  return 3'd2;
      Msize4:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] nib_inc(input logic [3:0] cnt);
    return (cnt == 4'hf) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/lpc_nibble_acc.sv
// Nibble accumulator used for both the address and the data path of the LPC decoder.
// Ports:
//   clk_i    clock (rising edge)
//   rst_i    synchronous active-high reset
//   clear_i  zero the register (takes priority over load_i)
//   load_i   accept nib_i this cycle
//   mode_i   AccMsbFirst: shift left, new nibble enters at the bottom (address order)
//            AccLowNibFirst: write nib_i into nibble slot idx_i (low nibble first, bytes ascending)
//   nib_i    incoming nibble
//   idx_i    nibble slot for AccLowNibFirst mode
//   value_o  accumulated value
module lpc_nibble_acc
  import lpc_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             mode_i,
  input  logic [3:0]       nib_i,
  input  logic [3:0]       idx_i,
  output logic [Width-1:0] value_o
);

  logic [Width-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = '0;
    end else if (load_i) begin
      if (mode_i == AccMsbFirst) begin
        value_d = {value_q[Width-5:0], nib_i};
      end else begin
        for (int unsigned i = 0; i < Width / 4; i++) begin
          if (idx_i == 4'(i)) value_d[4*i +: 4] = nib_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC bus decoder: follows IO, memory and firmware-memory cycles on LAD/LFRAME#
// and presents each finished cycle as one strobed record.
// Ports:
//   lpc_clock         LPC clock, rising edge
//   lpc_reset         synchronous active-high reset
//   lpc_ad[3:0]       LAD bus
//   lpc_frame         LFRAME#, active low
//   out_cyctype_dir   {type[1:0], dir, 1'b0}; type 00 IO, 01 mem, 11 firmware; dir 1 = write
//   out_addr          decoded address, zero-extended
//   out_data          data bytes, byte i at [8i+7:8i]
//   out_data_size     data byte count (0 on MSIZE error)
//   out_clock_enable  one-cycle record strobe
//   out_error         record carries a SYNC error, timeout or illegal MSIZE
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 4,
  parameter int unsigned SYNC_TIMEOUT   = 64,
  parameter int unsigned ENABLE_FW      = 1
) (
  input  logic                        lpc_clock,
  input  logic                        lpc_reset,
  input  logic [3:0]                  lpc_ad,
  input  logic                        lpc_frame,
  output logic [CtDirW-1:0]           out_cyctype_dir,
  output logic [AddrW-1:0]            out_addr,
  output logic [8*MAX_DATA_BYTES-1:0] out_data,
  output logic [SizeW-1:0]            out_data_size,
  output logic                        out_clock_enable,
  output logic                        out_error
);

  localparam int unsigned DataW = 8 * MAX_DATA_BYTES;
  localparam int unsigned WaitW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SYNC_TIMEOUT - 1);

  lpc_state_e        state_q;
  logic [3:0]        nib_cnt_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic              sticky_err_q;
  logic [CtDirW-1:0] ctdir_q;
  logic [SizeW-1:0]  size_q;

  logic [AddrW-1:0] addr_acc;
  logic [DataW-1:0] data_acc;
  logic             acc_clear, addr_load, data_load;
  logic             is_fw, is_wr, is_wait;
  logic [3:0]       addr_last, data_last;
  logic [SizeW-1:0] msize_sz;
  logic             msize_ok;
  logic             emit, emit_err;

  always_comb begin
    acc_clear = ~lpc_frame;
    addr_load = lpc_frame && (state_q == StAddr);
    data_load = lpc_frame && (state_q == StDataW || state_q == StDataR);
    is_fw     = (ctdir_q[3:2] == CtFw);
    is_wr     = ctdir_q[1];
    is_wait   = (lpc_ad == SyncShortWait) || (lpc_ad == SyncLongWait);
    case (ctdir_q[3:2])
      CtIo:    addr_last = 4'd3;
      CtMem:   addr_last = 4'd7;
      default: addr_last = 4'd6;
    endcase
    data_last = {size_q, 1'b0} - 4'd1;
    msize_sz  = msize_bytes(lpc_ad);
    msize_ok  = (msize_sz != 3'd0) && (32'(msize_sz) <= MAX_DATA_BYTES);

    // Record emission: normal end of cycle or an error that terminates it early
    emit     = 1'b0;
    emit_err = 1'b0;
    if (lpc_frame) begin
      case (state_q)
        StMsize: begin
          emit     = ~msize_ok;
          emit_err = 1'b1;
        end
        StSync: begin
          if (is_wait) emit = (wait_cnt_q >= WaitLast);
          else         emit = (lpc_ad != SyncReady) && (lpc_ad != SyncError);
          emit_err = 1'b1;
        end
        StTar2: begin
          emit     = (nib_cnt_q == 4'd1);
          emit_err = sticky_err_q;
        end
        default: ;
      endcase
    end
  end

  lpc_nibble_acc #(
    .Width(AddrW)
  ) u_addr_acc (
    .clk_i  (lpc_clock),
    .rst_i  (lpc_reset),
    .clear_i(acc_clear),
    .load_i (addr_load),
    .mode_i (AccMsbFirst),
    .nib_i  (lpc_ad),
    .idx_i  (nib_cnt_q),
    .value_o(addr_acc)
  );

  lpc_nibble_acc #(
    .Width(DataW)
  ) u_data_acc (
    .clk_i  (lpc_clock),
    .rst_i  (lpc_reset),
    .clear_i(acc_clear),
    .load_i (data_load),
    .mode_i (AccLowNibFirst),
    .nib_i  (lpc_ad),
    .idx_i  (nib_cnt_q),
    .value_o(data_acc)
  );

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state_q          <= StIdle;
      nib_cnt_q        <= '0;
      wait_cnt_q       <= '0;
      sticky_err_q     <= 1'b0;
      ctdir_q          <= '0;
      size_q           <= '0;
      out_cyctype_dir  <= '0;
      out_addr         <= '0;
      out_data         <= '0;
      out_data_size    <= '0;
      out_clock_enable <= 1'b0;
      out_error        <= 1'b0;
    end else begin
      out_clock_enable <= emit;
      if (emit) begin
        out_cyctype_dir <= ctdir_q;
        out_addr        <= addr_acc;
        out_data        <= data_acc;
        out_data_size   <= (state_q == StMsize) ? '0 : size_q;
        out_error       <= emit_err;
      end

      if (!lpc_frame) begin
        // Any frame-low sample restarts decode; the last START nibble wins
        nib_cnt_q    <= '0;
        wait_cnt_q   <= '0;
        sticky_err_q <= 1'b0;
        size_q       <= 3'd1;
        if (lpc_ad == StartLpc) begin
          state_q <= StCtdir;
        end else if (ENABLE_FW != 0 && (lpc_ad == StartFwRd || lpc_ad == StartFwWr)) begin
          state_q <= StIdsel;
          ctdir_q <= {CtFw, lpc_ad == StartFwWr, 1'b0};
        end else begin
          state_q <= StIdle;
        end
      end else begin
        unique case (state_q)
          StIdle, StDone: state_q <= StIdle;
          StCtdir: begin
            if (lpc_ad[3:2] == CtIo || lpc_ad[3:2] == CtMem) begin
              ctdir_q <= {lpc_ad[3:1], 1'b0};
              state_q <= StAddr;
            end else begin
              state_q <= StIdle;
            end
          end
          StIdsel: state_q <= StAddr;
          StAddr: begin
            if (nib_cnt_q == addr_last) begin
              nib_cnt_q <= '0;
              if (is_fw)      state_q <= StMsize;
              else if (is_wr) state_q <= StDataW;
              else            state_q <= StTar1;
            end else begin
              nib_cnt_q <= nib_inc(nib_cnt_q);
            end
          end
          StMsize: begin
            if (msize_ok) begin
              size_q  <= msize_sz;
              state_q <= is_wr ? StDataW : StTar1;
            end else begin
              state_q <= StDone;
            end
          end
          StDataW: begin
            if (nib_cnt_q == data_last) begin
              nib_cnt_q <= '0;
              state_q   <= StTar1;
            end else begin
              nib_cnt_q <= nib_inc(nib_cnt_q);
            end
          end
          StTar1: begin
            if (nib_cnt_q == 4'd1) begin
              nib_cnt_q <= '0;
              state_q   <= StSync;
            end else begin
              nib_cnt_q <= nib_inc(nib_cnt_q);
            end
          end
          StSync: begin
            if (lpc_ad == SyncReady || lpc_ad == SyncError) begin
              sticky_err_q <= sticky_err_q | (lpc_ad == SyncError);
              state_q      <= is_wr ? StTar2 : StDataR;
            end else if (is_wait) begin
              if (wait_cnt_q >= WaitLast) state_q <= StDone;
              else                        wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
              state_q <= StDone;
            end
          end
          StDataR: begin
            if (nib_cnt_q == data_last) begin
              nib_cnt_q <= '0;
              state_q   <= StTar2;
            end else begin
              nib_cnt_q <= nib_inc(nib_cnt_q);
            end
          end
          StTar2: begin
            if (nib_cnt_q == 4'd1) begin
              nib_cnt_q <= '0;
              state_q   <= StDone;
            end else begin
              nib_cnt_q <= nib_inc(nib_cnt_q);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Self-checking bench for lpc_cycle_decoder. Two instances share LAD and reset but have
// separate LFRAME# lines: dut_a uses the default parameters, dut_b uses MAX_DATA_BYTES=2 and
// SYNC_TIMEOUT=4. Expected records are queued as each cycle is driven, tagged with the sample
// index of the nibble that should trigger them, and popped when a strobe appears.
module tb_lpc_cycle_decoder;

  typedef struct {
    logic [3:0]  ct;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic        err;
    bit          full;
    bit          chk_size;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  lad;
  logic        fa, fb;

  logic [3:0]  ct_a, ct_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] data_a;
  logic [15:0] data_b;
  logic [2:0]  size_a, size_b;
  logic        ce_a, ce_b, err_a, err_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sample_no = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  lpc_cycle_decoder dut_a (
    .lpc_clock       (clk),
    .lpc_reset       (rst),
    .lpc_ad          (lad),
    .lpc_frame       (fa),
    .out_cyctype_dir (ct_a),
    .out_addr        (addr_a),
    .out_data        (data_a),
    .out_data_size   (size_a),
    .out_clock_enable(ce_a),
    .out_error       (err_a)
  );

  lpc_cycle_decoder #(
    .MAX_DATA_BYTES(2),
    .SYNC_TIMEOUT  (4),
    .ENABLE_FW     (1)
  ) dut_b (
    .lpc_clock       (clk),
    .lpc_reset       (rst),
    .lpc_ad          (lad),
    .lpc_frame       (fb),
    .out_cyctype_dir (ct_b),
    .out_addr        (addr_b),
    .out_data        (data_b),
    .out_data_size   (size_b),
    .out_clock_enable(ce_b),
    .out_error       (err_b)
  );

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  task automatic check_rec(input string tag, input exp_t e, input logic [3:0] ct,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] size, input logic err);
    cmp({tag, "_strobe_sample"}, sample_no, e.at);
    cmp({tag, "_err"}, 32'(err), 32'(e.err));
    if (e.full || e.chk_size) cmp({tag, "_size"}, 32'(size), 32'(e.size));
    if (e.full) begin
      cmp({tag, "_ct"}, 32'(ct), 32'(e.ct));
      cmp({tag, "_addr"}, addr, e.addr);
      cmp({tag, "_data"}, data, e.data);
    end
  endtask

  // Strobe monitor, sampling away from the active edge
  always @(negedge clk) begin
    if (ce_a === 1'b1) begin
      cmp("a_strobe_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) begin
        ea = qa.pop_front();
        check_rec("a", ea, ct_a, addr_a, data_a, size_a, err_a);
      end
    end
    if (ce_b === 1'b1) begin
      cmp("b_strobe_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        eb = qb.pop_front();
        check_rec("b", eb, ct_b, addr_b, {16'd0, data_b}, size_b, err_b);
      end
    end
  end

  task automatic nib(input logic frame_a, input logic frame_b, input logic [3:0] v);
    fa  = frame_a;
    fb  = frame_b;
    lad = v;
    @(posedge clk);
    #1;
    sample_no++;
  endtask

  task automatic d(input logic [3:0] v);
    nib(1'b1, 1'b1, v);
  endtask

  task automatic lpc_start(input bit sel, input logic [3:0] code);
    nib(sel ? 1'b1 : 1'b0, sel ? 1'b0 : 1'b1, code);
  endtask

  task automatic push(input bit sel, input exp_t e);
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // IO or memory cycle; ct selects type and direction, syncv is the final SYNC nibble
  task automatic lpc_cycle(input bit sel, input logic [3:0] ct, input logic [31:0] addr,
                           input logic [7:0] data, input int waits, input logic [3:0] syncv);
    exp_t e;
    int   na;
    bit   wr, fatal;
    na    = (ct[3:2] == 2'b01) ? 8 : 4;
    wr    = ct[1];
    fatal = !(syncv == 4'h0 || syncv == 4'ha);
    e.ct       = {ct[3:1], 1'b0};
    e.addr     = (na == 4) ? {16'd0, addr[15:0]} : addr;
    e.data     = {24'd0, data};
    e.size     = 3'd1;
    e.err      = (syncv != 4'h0);
    e.full     = !fatal;
    e.chk_size = !fatal;
    e.at       = 0;
    lpc_start(sel, 4'h0);
    d(ct);
    for (int i = na - 1; i >= 0; i--) d(addr[4*i +: 4]);
    if (wr) begin
      d(data[3:0]);
      d(data[7:4]);
    end
    d(4'hf);
    d(4'hf);
    for (int i = 0; i < waits; i++) d((i % 2 == 0) ? 4'h6 : 4'h5);
    d(syncv);
    if (fatal) begin
      e.at = sample_no;
      push(sel, e);
      d(4'hf);
      d(4'hf);
    end else begin
      if (!wr) begin
        d(data[3:0]);
        d(data[7:4]);
      end
      d(4'hf);
      d(4'hf);
      e.at = sample_no;
      push(sel, e);
    end
  endtask

  // Firmware cycle; msize_bad marks an MSIZE the instance must reject
  task automatic fw_cycle(input bit sel, input bit wr, input logic [27:0] addr,
                          input logic [3:0] msize, input logic [31:0] data, input int nbytes,
                          input bit msize_bad);
    exp_t e;
    e.ct       = wr ? 4'he : 4'hc;
    e.addr     = {4'd0, addr};
    e.data     = data;
    e.size     = msize_bad ? 3'd0 : 3'(nbytes);
    e.err      = msize_bad;
    e.full     = !msize_bad;
    e.chk_size = 1'b1;
    e.at       = 0;
    lpc_start(sel, wr ? 4'he : 4'hd);
    d(4'h0);
    for (int i = 6; i >= 0; i--) d(addr[4*i +: 4]);
    d(msize);
    if (msize_bad) begin
      e.at = sample_no;
      push(sel, e);
    end
    if (wr) begin
      for (int b = 0; b < nbytes; b++) begin
        d(data[8*b +: 4]);
        d(data[8*b+4 +: 4]);
      end
      d(4'hf);
      d(4'hf);
      d(4'h0);
    end else begin
      d(4'hf);
      d(4'hf);
      d(4'h0);
      for (int b = 0; b < nbytes; b++) begin
        d(data[8*b +: 4]);
        d(data[8*b+4 +: 4]);
      end
    end
    d(4'hf);
    d(4'hf);
    if (!msize_bad) begin
      e.at = sample_no;
      push(sel, e);
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    lad = 4'hf;
    fa  = 1'b1;
    fb  = 1'b1;
    d(4'hf);
    d(4'hf);
    rst = 1'b0;
    d(4'hf);

    cmp("rst_a_ce", 32'(ce_a), 32'd0);
    cmp("rst_a_err", 32'(err_a), 32'd0);
    cmp("rst_a_addr", addr_a, 32'd0);
    cmp("rst_a_data", data_a, 32'd0);
    cmp("rst_a_size", 32'(size_a), 32'd0);
    cmp("rst_a_ct", 32'(ct_a), 32'd0);
    cmp("rst_b_ce", 32'(ce_b), 32'd0);
    cmp("rst_b_addr", addr_b, 32'd0);

    lpc_cycle(1'b0, 4'h2, 32'h7fe5, 8'h6c, 0, 4'h0);      // IO write
    lpc_cycle(1'b0, 4'h0, 32'h0080, 8'ha5, 3, 4'h0);      // IO read, 3 waits
    lpc_cycle(1'b0, 4'h0, 32'h0081, 8'h5a, 0, 4'h0);      // IO read, no wait
    lpc_cycle(1'b0, 4'h6, 32'hfeedf00d, 8'h3c, 0, 4'h0);  // memory write
    fw_cycle(1'b0, 1'b0, 28'hffffff0, 4'h2, 32'h44332211, 4, 1'b0);
    fw_cycle(1'b0, 1'b1, 28'h0123456, 4'h1, 32'h00005678, 2, 1'b0);

    // Abort during the third address nibble, then a clean IO write
    lpc_start(1'b0, 4'h0);
    d(4'h2);
    d(4'h1);
    d(4'h2);
    nib(1'b0, 1'b1, 4'hf);
    d(4'hf);
    lpc_cycle(1'b0, 4'h2, 32'h0042, 8'h99, 0, 4'h0);

    lpc_cycle(1'b0, 4'h4, 32'h12345678, 8'he7, 1, 4'ha);  // sticky SYNC error
    lpc_cycle(1'b0, 4'h2, 32'h1111, 8'h22, 0, 4'h3);      // illegal SYNC
    lpc_cycle(1'b0, 4'h2, 32'hbeef, 8'h01, 0, 4'h0);      // back to back
    lpc_cycle(1'b0, 4'h2, 32'hcafe, 8'h02, 0, 4'h0);

    // Reset in the middle of a cycle drops it and clears the outputs
    lpc_start(1'b0, 4'h0);
    d(4'h2);
    d(4'h1);
    rst = 1'b1;
    d(4'hf);
    rst = 1'b0;
    cmp("midrst_a_ce", 32'(ce_a), 32'd0);
    cmp("midrst_a_addr", addr_a, 32'd0);
    cmp("midrst_a_data", data_a, 32'd0);
    d(4'h2);
    d(4'h3);
    lpc_cycle(1'b0, 4'h2, 32'h00a0, 8'h77, 0, 4'h0);

    // Narrow instance: 4-byte MSIZE rejected, 2-byte accepted
    fw_cycle(1'b1, 1'b0, 28'hffffff0, 4'h2, 32'h44332211, 4, 1'b1);
    fw_cycle(1'b1, 1'b0, 28'h0000100, 4'h1, 32'h0000bbaa, 2, 1'b0);

    // Timeout after the fourth wait nibble
    lpc_start(1'b1, 4'h0);
    d(4'h0);
    d(4'h0);
    d(4'h0);
    d(4'h1);
    d(4'h0);
    d(4'hf);
    d(4'hf);
    for (int i = 0; i < 4; i++) d(4'h5);
    e.ct       = 4'h0;
    e.addr     = 32'd0;
    e.data     = 32'd0;
    e.size     = 3'd0;
    e.err      = 1'b1;
    e.full     = 1'b0;
    e.chk_size = 1'b0;
    e.at       = sample_no;
    qb.push_back(e);
    d(4'h5);
    d(4'hf);
    lpc_cycle(1'b1, 4'h2, 32'h0310, 8'h4d, 0, 4'h0);

    for (int i = 0; i < 4; i++) d(4'hf);
    cmp("a_pending_records", qa.size(), 32'd0);
    cmp("b_pending_records", qb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
